demux_router: RTL and testbench

Stream demultiplexer that routes each accepted input word to one of four output lanes, selected by a 2-bit lane index carried with the word. It is the inverse of the team's 4-to-1 select block: one source fans out to four sinks. Each lane has its own 2-entry buffer, so a stalled sink blocks only words addressed to it. It sits between a single producer and four independent consumers in the NPC lab datapath.

---
 rtl/demux_router.sv | 149 ++++++++++++++
 tb/tb_demux_router.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_router.sv
// -----------------------------------------------------------------------------
// demux_router
//   Stream demultiplexer. It takes one word per cycle from a single producer
//   and routes it to one of four output lanes, chosen by in_sel. Each lane
//   has its own 2-entry FIFO (head/tail registers), so a stalled consumer
//   only blocks words addressed to its own lane.
//
// Ports
//   clk        input   clock, all state updates on the rising edge
//   rst        input   asynchronous, active-low reset
//   in_valid   input   producer offers a word
//   in_ready   output  addressed lane (in_sel) is not full
//   in_data    input   W-bit word payload
//   in_sel     input   2-bit destination lane
//   out_valid  output  bit i: lane i head entry valid
//   out_ready  input   bit i: consumer i takes the head entry
//   out_data   output  lane i head payload on bits [i*W +: W]
//   stat_cnt   output  per-lane saturating 8-bit transfer counters
//                      (only when DEMUX_STATS_EN is defined)
//
// Build option
//   DEMUX_STATS_EN : adds the stat_cnt port and its counters.
// -----------------------------------------------------------------------------
module demux_router #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic [1:0]     in_sel,
  output logic [3:0]     out_valid,
  input  logic [3:0]     out_ready,
  output logic [4*W-1:0] out_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [31:0]    stat_cnt
`endif
);

  // Lane occupancy encoding
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]   occ_q  [4];
  logic [1:0]   occ_d  [4];
  logic [W-1:0] head_q [4];
  logic [W-1:0] head_d [4];
  logic [W-1:0] tail_q [4];
  logic [W-1:0] tail_d [4];
  logic [3:0]   push;
  logic [3:0]   pop;

  // Full is taken from registered occupancy only, so a pop in the same cycle
  // never opens the input; this keeps out_ready off the in_ready path.
  assign in_ready = (occ_q[in_sel] != TWO);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      out_valid[i]       = (occ_q[i] != EMPTY);
      out_data[i*W +: W] = head_q[i];
      push[i]            = in_valid && in_ready && (in_sel == 2'(i));
      pop[i]             = (occ_q[i] != EMPTY) && out_ready[i];
    end
  end

  // Per-lane FIFO next state. When a push and pop coincide in ONE, the new
  // word replaces the departing head directly instead of passing via tail.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      occ_d[i]  = occ_q[i];
      head_d[i] = head_q[i];
      tail_d[i] = tail_q[i];
      case (occ_q[i])
        EMPTY: begin
          if (push[i]) begin
            occ_d[i]  = ONE;
            head_d[i] = in_data;
          end
        end
        ONE: begin
          if (push[i] && pop[i]) begin
            head_d[i] = in_data;
          end else if (push[i]) begin
            occ_d[i]  = TWO;
            tail_d[i] = in_data;
          end else if (pop[i]) begin
            occ_d[i]  = EMPTY;
          end
        end
        TWO: begin
          if (pop[i]) begin
            occ_d[i]  = ONE;
            head_d[i] = tail_q[i];
          end
        end
        default: occ_d[i] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        occ_q[i]  <= EMPTY;
        head_q[i] <= '0;
        tail_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        occ_q[i]  <= occ_d[i];
        head_q[i] <= head_d[i];
        tail_q[i] <= tail_d[i];
      end
    end
  end

`ifdef DEMUX_STATS_EN
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];

  // Counters saturate at 255 rather than wrapping.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (pop[i] && (cnt_q[i] != 8'hFF)) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign stat_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_demux_router.sv
// -----------------------------------------------------------------------------
// tb_demux_router
//   Directed self-checking bench for demux_router. Inputs change 1 ns after
//   the rising edge; outputs are sampled at that point or 1 ns later.
// -----------------------------------------------------------------------------
module tb_demux_router;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
`ifdef DEMUX_STATS_EN
  logic [31:0] stat_cnt;
`endif

  int compared;
  int mismatched;

  demux_router #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX_STATS_EN
    ,
    .stat_cnt  (stat_cnt)
`endif
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      in_sel    = 2'($urandom);
      out_ready = 4'($urandom);
      tick();
    end
    #1;
    compared++;
    if (out_valid !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_valid: got %b expected 0000", out_valid);
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    compared++;
    if (out_data !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_data: got %h expected 00000000", out_data);
    end
`ifdef DEMUX_STATS_EN
    compared++;
    if (stat_cnt !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_stat: got %h expected 00000000", stat_cnt);
    end
`endif
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_sel    = 2'd0;
    out_ready = 4'b0000;
    rst       = 1'b1;
    tick();
    compared++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL post_reset: got valid=%b ready=%b expected 0000/1", out_valid, in_ready);
    end
  endtask

  task automatic test_single_route();
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    in_data   = 8'hA5;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL route_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    compared++;
    if (out_valid !== 4'b0100 || out_data[23:16] !== 8'hA5) begin
      mismatched++;
      $display("[TB] FAIL route_out: got valid=%b data=%h expected 0100/a5", out_valid, out_data[23:16]);
    end
    tick();
    compared++;
    if (out_valid !== 4'b0000 || out_data[23:16] !== 8'hA5) begin
      mismatched++;
      $display("[TB] FAIL route_drain: got valid=%b data=%h expected 0000/a5 held", out_valid, out_data[23:16]);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    in_data   = 8'h11;
    tick();
    in_data = 8'h22;
    tick();
    in_data = 8'h33;
    #1;
    compared++;
    if (in_ready !== 1'b0 || out_valid !== 4'b0010 || out_data[15:8] !== 8'h11) begin
      mismatched++;
      $display("[TB] FAIL bp_full: got ready=%b valid=%b data=%h expected 0/0010/11", in_ready, out_valid, out_data[15:8]);
    end
    tick();
    // Stalled edge: head must not move and 33 must not be taken
    out_ready = 4'b0010;
    #1;
    compared++;
    if (in_ready !== 1'b0 || out_data[15:8] !== 8'h11) begin
      mismatched++;
      $display("[TB] FAIL bp_full_pop: got ready=%b data=%h expected 0/11", in_ready, out_data[15:8]);
    end
    tick();
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 4'b0010 || out_data[15:8] !== 8'h22) begin
      mismatched++;
      $display("[TB] FAIL bp_second: got ready=%b valid=%b data=%h expected 1/0010/22", in_ready, out_valid, out_data[15:8]);
    end
    tick();
    in_valid = 1'b0;
    compared++;
    if (out_valid !== 4'b0010 || out_data[15:8] !== 8'h33) begin
      mismatched++;
      $display("[TB] FAIL bp_third: got valid=%b data=%h expected 0010/33", out_valid, out_data[15:8]);
    end
    tick();
    compared++;
    if (out_valid !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL bp_empty: got %b expected 0000", out_valid);
    end
  endtask

  task automatic test_lane_isolation();
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 8'h55;
    tick();
    in_data = 8'h66;
    tick();
    #1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL iso_lane0_full: got ready=%b expected 0", in_ready);
    end
    in_sel  = 2'd3;
    in_data = 8'h44;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL iso_lane3_ready: got ready=%b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    compared++;
    if (out_valid !== 4'b1001 || out_data[31:24] !== 8'h44 || out_data[7:0] !== 8'h55) begin
      mismatched++;
      $display("[TB] FAIL iso_out: got valid=%b l3=%h l0=%h expected 1001/44/55", out_valid, out_data[31:24], out_data[7:0]);
    end
    out_ready = 4'b1111;
    tick();
    compared++;
    if (out_valid !== 4'b0001 || out_data[7:0] !== 8'h66) begin
      mismatched++;
      $display("[TB] FAIL iso_drain1: got valid=%b l0=%h expected 0001/66", out_valid, out_data[7:0]);
    end
    tick();
    compared++;
    if (out_valid !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL iso_drain2: got %b expected 0000", out_valid);
    end
  endtask

  task automatic test_push_pop_one();
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 8'h01;
    tick();
    out_ready = 4'b0001;
    in_data   = 8'h02;
    #1;
    compared++;
    if (in_ready !== 1'b1 || out_data[7:0] !== 8'h01) begin
      mismatched++;
      $display("[TB] FAIL pp_before: got ready=%b l0=%h expected 1/01", in_ready, out_data[7:0]);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    #1;
    compared++;
    if (out_valid !== 4'b0001 || out_data[7:0] !== 8'h02 || in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL pp_after: got valid=%b l0=%h ready=%b expected 0001/02/1", out_valid, out_data[7:0], in_ready);
    end
    // One more push must fill the lane if occupancy really was one
    in_valid = 1'b1;
    in_data  = 8'h03;
    tick();
    in_valid = 1'b0;
    compared++;
    if (in_ready !== 1'b0 || out_data[7:0] !== 8'h02) begin
      mismatched++;
      $display("[TB] FAIL pp_fill: got ready=%b l0=%h expected 0/02", in_ready, out_data[7:0]);
    end
    out_ready = 4'b1111;
    tick();
    compared++;
    if (out_data[7:0] !== 8'h03 || out_valid !== 4'b0001) begin
      mismatched++;
      $display("[TB] FAIL pp_tail: got valid=%b l0=%h expected 0001/03", out_valid, out_data[7:0]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] sel;
    logic [7:0] dat;
    out_ready = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      sel      = 2'(k);
      dat      = 8'h80 + 8'(k);
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = dat;
      tick();
      compared++;
      if (out_valid !== (4'b0001 << sel) || out_data[sel*8 +: 8] !== dat) begin
        mismatched++;
        $display("[TB] FAIL b2b_%0d: got valid=%b data=%h expected %b/%h", k, out_valid, out_data[sel*8 +: 8], 4'b0001 << sel, dat);
      end
    end
    in_valid = 1'b0;
    tick();
    compared++;
    if (out_valid !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL b2b_drain: got %b expected 0000", out_valid);
    end
  endtask

`ifdef DEMUX_STATS_EN
  task automatic test_stats();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    for (int k = 0; k < 300; k++) begin
      in_data = 8'(k);
      tick();
    end
    in_sel = 2'd2;
    for (int k = 0; k < 5; k++) begin
      in_data = 8'(k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    compared++;
    if (stat_cnt !== 32'h0005_00FF) begin
      mismatched++;
      $display("[TB] FAIL stat_count: got %h expected 000500ff", stat_cnt);
    end
  endtask
`endif

  task automatic test_reset_midstream();
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    in_data   = 8'h9C;
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    compared++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1 || out_data !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset: got valid=%b ready=%b data=%h expected 0000/1/0", out_valid, in_ready, out_data);
    end
`ifdef DEMUX_STATS_EN
    compared++;
    if (stat_cnt !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_stat: got %h expected 00000000", stat_cnt);
    end
`endif
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_sel     = 2'd0;
    out_ready  = 4'b0000;
    test_reset();
    test_single_route();
    test_backpressure();
    test_lane_isolation();
    test_push_pop_one();
    test_back_to_back();
`ifdef DEMUX_STATS_EN
    test_stats();
`endif
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
